// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data port.
// One access is outstanding at a time; the result returns as a one-cycle valid pulse.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_valid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_be_i,
  output logic        dm_gnt_o,
  output logic        dm_valid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_if_o,
  output logic        stall_dm_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_dm_rdata;
  logic          r_if_valid;
  logic          r_dm_valid;
  logic          r_flush_pend;
  logic [CW-1:0] r_starve;

  logic w_if_elig;
  logic w_dm_elig;
  logic w_starved;
  logic w_if_gnt;
  logic w_dm_gnt;

  // A port whose valid is high is still showing the request that just finished.
  assign w_if_elig = if_req_i & ~r_if_valid;
  assign w_dm_elig = dm_req_i & ~r_dm_valid;
  assign w_starved = (r_starve == CW'(STARVE_MAX));

  always_comb begin
    w_state_next = r_state;
    w_if_gnt     = 1'b0;
    w_dm_gnt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          if (w_if_elig && (!w_dm_elig || w_starved)) begin
            w_if_gnt     = 1'b1;
            w_state_next = BUSY_IF;
          end else if (w_dm_elig) begin
            w_dm_gnt     = 1'b1;
            w_state_next = BUSY_DM;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_if_gnt) begin
        r_addr  <= if_addr_i;
        r_wdata <= '0;
        r_we    <= 1'b0;
        r_be    <= 4'hF;
      end else if (w_dm_gnt) begin
        r_addr  <= dm_addr_i;
        r_wdata <= dm_wdata_i;
        r_we    <= dm_we_i;
        r_be    <= dm_be_i;
      end
    end
  end

  // A flush seen anywhere from grant up to completion cancels the fetch result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid   <= 1'b0;
      r_if_rdata   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      if (w_if_gnt) begin
        r_flush_pend <= if_flush_i;
      end else if (r_state == BUSY_IF) begin
        if (mem_ready_i) begin
          r_flush_pend <= 1'b0;
          if (!(r_flush_pend || if_flush_i)) begin
            r_if_valid <= 1'b1;
            r_if_rdata <= mem_rdata_i;
          end
        end else if (if_flush_i) begin
          r_flush_pend <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dm_valid <= 1'b0;
      r_dm_rdata <= '0;
    end else begin
      r_dm_valid <= 1'b0;
      if (r_state == BUSY_DM && mem_ready_i) begin
        r_dm_valid <= 1'b1;
        if (!r_we) begin
          r_dm_rdata <= mem_rdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!if_req_i || w_if_gnt) begin
      r_starve <= '0;
    end else if (w_dm_gnt && !w_starved) begin
      r_starve <= r_starve + CW'(1);
    end
  end

  assign if_gnt_o    = w_if_gnt;
  assign dm_gnt_o    = w_dm_gnt;
  assign if_valid_o  = r_if_valid;
  assign dm_valid_o  = r_dm_valid;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign mem_req_o   = (r_state != IDLE);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign stall_if_o  = if_req_i & ~r_if_valid;
  assign stall_dm_o  = dm_req_i & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i, if_flush_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_valid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i, dm_we_i;
  logic [31:0] dm_addr_i, dm_wdata_i;
  logic [3:0]  dm_be_i;
  logic        dm_gnt_o, dm_valid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        stall_if_o, stall_dm_o;

  mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i),
    .dm_gnt_o(dm_gnt_o), .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_dm_o(stall_dm_o)
  );

  always #5 clk = ~clk;

  // Memory returns a value derived from the address it is presented with.
  assign mem_rdata_i = mem_addr_o + 32'h1000_0000;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc_n, act, exp);
    end
  endtask

  // Reference: who owns the memory, the latched transaction, pending pulses.
  int          m_owner;          // 0 none, 1 fetch, 2 data
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic        m_we;
  logic [3:0]  m_be;
  bit          m_if_v, m_dm_v, m_flushed;
  int          m_starve;
  bit          e_ig, e_dg, n_if_v, n_dm_v;

  initial begin
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) begin
        m_owner = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_be = '0;
        m_if_rdata = '0; m_dm_rdata = '0; m_if_v = 1'b0; m_dm_v = 1'b0;
        m_flushed = 1'b0; m_starve = 0;
        chk("rst_if_gnt", if_gnt_o, 0);
        chk("rst_dm_gnt", dm_gnt_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_if_valid", if_valid_o, 0);
        chk("rst_dm_valid", dm_valid_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_dm_rdata", dm_rdata_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_stall_if", stall_if_o, if_req_i);
        chk("rst_stall_dm", stall_dm_o, dm_req_i);
      end else begin
        e_ig = (m_owner == 0) && if_req_i && !m_if_v &&
               (!(dm_req_i && !m_dm_v) || m_starve == SMAX);
        e_dg = (m_owner == 0) && dm_req_i && !m_dm_v && !e_ig;
        chk("if_gnt", if_gnt_o, e_ig);
        chk("dm_gnt", dm_gnt_o, e_dg);
        chk("mem_req", mem_req_o, m_owner != 0);
        if (m_owner != 0) begin
          chk("mem_addr", mem_addr_o, m_addr);
          chk("mem_we", mem_we_o, m_we);
          chk("mem_be", mem_be_o, m_be);
          if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
        end
        chk("if_valid", if_valid_o, m_if_v);
        chk("dm_valid", dm_valid_o, m_dm_v);
        chk("if_rdata", if_rdata_o, m_if_rdata);
        chk("dm_rdata", dm_rdata_o, m_dm_rdata);
        chk("stall_if", stall_if_o, if_req_i && !m_if_v);
        chk("stall_dm", stall_dm_o, dm_req_i && !m_dm_v);

        n_if_v = 1'b0;
        n_dm_v = 1'b0;
        if (m_owner == 1) begin
          if (if_flush_i) m_flushed = 1'b1;
          if (mem_ready_i) begin
            if (!m_flushed) begin
              n_if_v = 1'b1;
              m_if_rdata = mem_rdata_i;
            end
            m_flushed = 1'b0;
            m_owner = 0;
          end
        end else if (m_owner == 2) begin
          if (mem_ready_i) begin
            n_dm_v = 1'b1;
            if (!m_we) m_dm_rdata = mem_rdata_i;
            m_owner = 0;
          end
        end else if (e_ig) begin
          m_owner = 1; m_addr = if_addr_i; m_we = 1'b0; m_wdata = '0; m_be = 4'hF;
          m_flushed = if_flush_i;
        end else if (e_dg) begin
          m_owner = 2; m_addr = dm_addr_i; m_we = dm_we_i; m_wdata = dm_wdata_i;
          m_be = dm_be_i;
        end
        if (!if_req_i || e_ig) m_starve = 0;
        else if (e_dg && m_starve < SMAX) m_starve++;
        m_if_v = n_if_v;
        m_dm_v = n_dm_v;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0;
    mem_ready_i = 1'b1;

    // Reset: no grant even with a request present; stall follows inputs.
    cyc(); if_req_i = 1'b1;
    at_neg();
    chk("lit_rst_gnt", if_gnt_o, 0);
    chk("lit_rst_stall", stall_if_o, 1);
    cyc(); if_req_i = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc();

    // Single fetch at 0x100: gnt c0, mem_req c1, valid c2.
    cyc(); if_req_i = 1'b1; if_addr_i = 32'h100;
    at_neg(); chk("lit_f_gnt", if_gnt_o, 1);
    cyc(); at_neg();
    chk("lit_f_memreq", mem_req_o, 1);
    chk("lit_f_addr", mem_addr_o, 32'h100);
    chk("lit_f_be", mem_be_o, 4'hF);
    cyc(); at_neg();
    chk("lit_f_valid", if_valid_o, 1);
    chk("lit_f_rdata", if_rdata_o, 32'h1000_0100);
    chk("lit_f_nogrant", if_gnt_o, 0);
    cyc(); if_req_i = 1'b0;
    cyc();

    // Load at 0x300, then a store with three wait cycles.
    cyc(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300; dm_be_i = 4'hF;
    cyc(); cyc(); at_neg();
    chk("lit_ld_rdata", dm_rdata_o, 32'h1000_0300);
    cyc(); dm_req_i = 1'b0;
    cyc(); dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200;
    dm_wdata_i = 32'hDEAD_BEEF; dm_be_i = 4'b0011; mem_ready_i = 1'b0;
    at_neg(); chk("lit_st_gnt", dm_gnt_o, 1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      mem_ready_i = (k == 3);
      at_neg();
      chk("lit_st_memreq", mem_req_o, 1);
      chk("lit_st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      chk("lit_st_be", mem_be_o, 4'b0011);
      chk("lit_st_we", mem_we_o, 1);
      chk("lit_st_stall", stall_dm_o, 1);
    end
    cyc(); at_neg();
    chk("lit_st_valid", dm_valid_o, 1);
    chk("lit_st_rdata", dm_rdata_o, 32'h1000_0300);
    cyc(); dm_req_i = 1'b0; dm_we_i = 1'b0;
    cyc();

    // Flush the cycle after grant; the next fetch is arbitrated normally.
    cyc(); if_req_i = 1'b1; if_addr_i = 32'h400;
    at_neg(); chk("lit_fl_gnt", if_gnt_o, 1);
    cyc(); if_flush_i = 1'b1; mem_ready_i = 1'b0;
    cyc(); if_flush_i = 1'b0; mem_ready_i = 1'b1;
    at_neg(); chk("lit_fl_memreq", mem_req_o, 1);
    cyc(); if_addr_i = 32'h500;
    at_neg();
    chk("lit_fl_novalid", if_valid_o, 0);
    chk("lit_fl_regnt", if_gnt_o, 1);
    chk("lit_fl_rdata_held", if_rdata_o, 32'h1000_0100);
    cyc(); cyc(); at_neg();
    chk("lit_fl_valid2", if_valid_o, 1);
    chk("lit_fl_rdata2", if_rdata_o, 32'h1000_0500);
    cyc(); if_req_i = 1'b0;
    cyc();

    // Data completes while fetch waits: dm_valid and if_gnt together.
    cyc(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h600; dm_be_i = 4'hF;
    cyc(); if_req_i = 1'b1; if_addr_i = 32'h700;
    at_neg(); chk("lit_co_wait", if_gnt_o, 0);
    cyc(); at_neg();
    chk("lit_co_dmvalid", dm_valid_o, 1);
    chk("lit_co_ifgnt", if_gnt_o, 1);
    chk("lit_co_dmgnt", dm_gnt_o, 0);
    cyc(); dm_req_i = 1'b0;
    cyc(); at_neg();
    chk("lit_co_ifrdata", if_rdata_o, 32'h1000_0700);
    cyc(); if_req_i = 1'b0;
    cyc();

    // Reset while a store is stalled in memory.
    cyc(); dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h800; dm_wdata_i = 32'h1234_5678;
    mem_ready_i = 1'b0;
    cyc();
    cyc(); rst_n = 1'b0;
    at_neg(); chk("lit_rr_memreq", mem_req_o, 0);
    cyc(); rst_n = 1'b1; dm_req_i = 1'b0; dm_we_i = 1'b0; mem_ready_i = 1'b1;
    at_neg(); chk("lit_rr_novalid", dm_valid_o, 0);
    cyc(); if_req_i = 1'b1; if_addr_i = 32'h880;
    at_neg();
    chk("lit_rr_novalid2", dm_valid_o, 0);
    chk("lit_rr_idle_gnt", if_gnt_o, 1);
    cyc(); cyc(); if_req_i = 1'b0;
    cyc();

    // A data request withdrawn before grant leaves no trace.
    cyc(); if_req_i = 1'b1; if_addr_i = 32'h900; mem_ready_i = 1'b0;
    cyc(); dm_req_i = 1'b1; dm_addr_i = 32'hA00;
    cyc(); dm_req_i = 1'b0; mem_ready_i = 1'b1;
    cyc(); at_neg();
    chk("lit_dr_nogrant", dm_gnt_o, 0);
    chk("lit_dr_ifvalid", if_valid_o, 1);
    cyc(); if_req_i = 1'b0;
    cyc(); at_neg(); chk("lit_dr_idle", mem_req_o, 0);

    // Both ports requesting continuously, memory occasionally slow.
    for (int k = 0; k < 30; k++) begin
      cyc();
      if_req_i = 1'b1; if_addr_i = 32'h1000;
      dm_req_i = 1'b1; dm_we_i = (k >= 15); dm_addr_i = 32'h2000;
      dm_wdata_i = 32'hCAFE_0000; dm_be_i = 4'b1100;
      mem_ready_i = ((k % 3) != 2);
    end
    cyc(); mem_ready_i = 1'b1;
    repeat (6) cyc();
    if_req_i = 1'b0; dm_req_i = 1'b0;
    repeat (4) cyc();
    at_neg(); chk("lit_end_idle", mem_req_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
